// File: rtl/aftab_aau_pkg.sv
// Shared definitions for the AFTAB AAU requester: RV32M funct3 codes, FSM encoding, special operands.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aftab_aau_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic is_div;
        logic ss;
        logic su;
        logic uu;
        logic sel_h;
    } dec_t;

endpackage

// File: rtl/aftab_aau_req_decode.sv
// Maps an RV32M funct3 onto AAU controls: divide select, one-hot signedness, H/L result word.
// Latency: combinational.
// Backpressure: none.
module aftab_aau_req_decode
    import aftab_aau_pkg::*;
(
    input  logic [2:0] funct3,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.is_div = funct3[2];
        case (funct3)
            F3_MUL:    dec.ss = 1'b1;
            F3_MULH:   begin dec.ss = 1'b1; dec.sel_h = 1'b1; end
            F3_MULHSU: begin dec.su = 1'b1; dec.sel_h = 1'b1; end
            F3_MULHU:  begin dec.uu = 1'b1; dec.sel_h = 1'b1; end
            F3_DIV:    dec.ss = 1'b1;
            F3_DIVU:   dec.uu = 1'b1;
            F3_REM:    begin dec.ss = 1'b1; dec.sel_h = 1'b1; end
            F3_REMU:   begin dec.uu = 1'b1; dec.sel_h = 1'b1; end
            default:   dec = '0;
        endcase
    end

endmodule

// File: rtl/aftab_aau_requester.sv
// Core-side RV32M initiator for the AFTAB AAU: one op at a time, divide corner cases resolved locally.
// Latency: doneM 1 cycle after acceptance on bypass, else 1 cycle after completeAAU; watchdog abort.
// Backpressure: reqM is a held level, acknowledged by a single-cycle doneM pulse.
module aftab_aau_requester
    import aftab_aau_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqM,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] resultM,
    output logic        doneM,
    output logic        errM,
    output logic [31:0] A_AAU,
    output logic [31:0] B_AAU,
    output logic        multAAU,
    output logic        divideAAU,
    output logic        signedSigned,
    output logic        signedUnsigned,
    output logic        unsignedUnsigned,
    input  logic [31:0] H_AAU,
    input  logic [31:0] L_AAU,
    input  logic        completeAAU
);

    state_t      state, state_nxt;
    logic [6:0]  wd, wd_nxt;
    logic        sel_h, sel_h_nxt;
    logic [31:0] res_nxt, a_nxt, b_nxt;
    logic        done_nxt, err_nxt, mult_nxt, div_nxt;
    logic [2:0]  mode, mode_nxt;
    dec_t        dec;

    aftab_aau_req_decode u_decode (
        .funct3 (funct3),
        .dec    (dec)
    );

    assign mode = {signedSigned, signedUnsigned, unsignedUnsigned};

    always_comb begin
        state_nxt = state;
        wd_nxt    = wd;
        sel_h_nxt = sel_h;
        res_nxt   = resultM;
        a_nxt     = A_AAU;
        b_nxt     = B_AAU;
        done_nxt  = 1'b0;
        err_nxt   = errM;
        mult_nxt  = 1'b0;
        div_nxt   = 1'b0;
        mode_nxt  = mode;
        case (state)
            ST_IDLE: begin
                if (reqM) begin
                    err_nxt   = 1'b0;
                    a_nxt     = rs1;
                    b_nxt     = rs2;
                    sel_h_nxt = dec.sel_h;
                    if (dec.is_div && rs2 == '0) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        res_nxt   = dec.sel_h ? rs1 : ALL_ONES;
                    end else if (dec.is_div && dec.ss && rs1 == INT_MIN && rs2 == ALL_ONES) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        res_nxt   = dec.sel_h ? '0 : INT_MIN;
                    end else begin
                        state_nxt = ST_ISSUE;
                        mult_nxt  = ~dec.is_div;
                        div_nxt   = dec.is_div;
                        mode_nxt  = {dec.ss, dec.su, dec.uu};
                    end
                end
            end
            ST_ISSUE: begin
                wd_nxt    = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                wd_nxt = wd + 7'd1;
                if (completeAAU) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    res_nxt   = sel_h ? H_AAU : L_AAU;
                    mode_nxt  = '0;
                // abort on the edge where the count would reach TIMEOUT-1
                end else if (wd == 7'(TIMEOUT - 2)) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    res_nxt   = '0;
                    mode_nxt  = '0;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            wd               <= '0;
            sel_h            <= 1'b0;
            resultM          <= '0;
            doneM            <= 1'b0;
            errM             <= 1'b0;
            A_AAU            <= '0;
            B_AAU            <= '0;
            multAAU          <= 1'b0;
            divideAAU        <= 1'b0;
            signedSigned     <= 1'b0;
            signedUnsigned   <= 1'b0;
            unsignedUnsigned <= 1'b0;
        end else begin
            state            <= state_nxt;
            wd               <= wd_nxt;
            sel_h            <= sel_h_nxt;
            resultM          <= res_nxt;
            doneM            <= done_nxt;
            errM             <= err_nxt;
            A_AAU            <= a_nxt;
            B_AAU            <= b_nxt;
            multAAU          <= mult_nxt;
            divideAAU        <= div_nxt;
            signedSigned     <= mode_nxt[2];
            signedUnsigned   <= mode_nxt[1];
            unsignedUnsigned <= mode_nxt[0];
        end
    end

endmodule

// File: doc/aftab_aau_requester.md
# aftab_aau_requester

Core-side initiator for the AFTAB multiply/divide unit (aftab_AAU) in the datapath. It accepts one RV32M operation at a time from the core control path and decodes funct3 into AAU start and signedness controls. It waits for `completeAAU`, then selects the H or L word as the result and returns it with a single-cycle done pulse. Divide-by-zero and signed-overflow cases never reach the AAU; this block resolves them locally with RISC-V-mandated results.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles in WAIT before abort; 7-bit watchdog counter.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `reqM`  in  1  core request, level; held until `doneM`.
- `funct3`  in  3  RV32M operation code.
- `rs1`, `rs2`  in  32  operands.
- `resultM`  out  32  result; valid when `doneM`=1.
- `doneM`  out  1  one-cycle completion pulse.
- `errM`  out  1  timeout flag; valid with `doneM`.
- `A_AAU`, `B_AAU`  out  32  operands to AAU; held from ISSUE until exit from WAIT.
- `multAAU`, `divideAAU`  out  1  one-cycle start pulses to AAU.
- `signedSigned`, `signedUnsigned`, `unsignedUnsigned`  out  1  one-hot mode; held stable from ISSUE until exit from WAIT.
- `H_AAU`, `L_AAU`  in  32  AAU result words. Multiply: product high/low. Divide: remainder/quotient.
- `completeAAU`  in  1  AAU completion pulse.

## Operation
- Decode by funct3:
  - 000 MUL: SS, result L.
  - 001 MULH: SS, result H.
  - 010 MULHSU: SU, result H.
  - 011 MULHU: UU, result H.
  - 100 DIV: SS, result L.
  - 101 DIVU: UU, result L.
  - 110 REM: SS, result H.
  - 111 REMU: UU, result H.
- FSM states IDLE, ISSUE, WAIT, DONE.
  - IDLE: on `reqM`=1, latch `funct3`, `rs1` and `rs2`.
    - Divide op with `rs2`==0: go to DONE. Result is 0xFFFFFFFF for DIV/DIVU, `rs1` for REM/REMU.
    - DIV/REM with `rs1`=0x80000000 and `rs2`=0xFFFFFFFF: go to DONE. Result is 0x80000000 for DIV, 0 for REM.
    - Otherwise go to ISSUE.
  - ISSUE: assert `multAAU` or `divideAAU` for exactly one cycle; clear the watchdog; go to WAIT.
  - WAIT: the watchdog increments each cycle.
    - On `completeAAU`=1: capture the selected word into `resultM` and go to DONE.
    - If the count reaches `TIMEOUT`-1 first: set `resultM`=0 and `errM`=1, then go to DONE.
  - DONE: `doneM`=1 for one cycle; go to IDLE.
- A `completeAAU` pulse seen in IDLE, ISSUE or DONE is ignored.
- If `completeAAU` and the watchdog limit occur in the same cycle, completion wins and `errM`=0.
- `resultM` holds its value until the next DONE. `errM` clears on the next accepted request.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, `resultM`=0, FSM in IDLE, watchdog 0.
- Bypass path: request sampled at edge n; `doneM` is high in cycle n+1.
- Normal path: request sampled at edge n; start pulse in cycle n+1. If `completeAAU` is high in cycle k (k ≥ n+2), `doneM` is high in cycle k+1.
- Back-to-back operation: if `reqM` is still high in the IDLE cycle after DONE, a new request is accepted. The core must drop `reqM` in the `doneM` cycle to avoid a duplicate request.
- Reset asserted mid-operation: FSM returns to IDLE immediately and any pulses stop. The integration must reset the AAU in the same event; its active-high reset is the inverted `rst`.

## Structure
- Shared package `aftab_aau_pkg`:
  - funct3 localparams.
  - FSM state encoding, 2 bits.
  - Special-case constants 0x80000000 and 0xFFFFFFFF.
- One natural sub-module, `aftab_aau_req_decode` (combinational): funct3 → {is_div, mode one-hot, sel_H}.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- MULH, `rs1`=40, `rs2`=-2; AAU model returns H=0xFFFFFFFF, L=0xFFFFFFB0 after 34 cycles -> one `multAAU` pulse, `signedSigned`=1, `resultM`=0xFFFFFFFF, one `doneM` pulse, `errM`=0.
- DIVU then REMU, 121/7; AAU returns L=17, H=2 -> `resultM`=17, then 2. `unsignedUnsigned`=1 for both; requests issued back-to-back.
- DIV, `rs2`=0, `rs1`=5 -> no `divideAAU` pulse, `resultM`=0xFFFFFFFF, `doneM` one cycle after acceptance. Same stimulus with REM -> `resultM`=5.
- DIV 0x80000000 / 0xFFFFFFFF -> bypass, `resultM`=0x80000000. Same operands with REM -> `resultM`=0.
- MUL with the AAU model never completing -> `doneM`=1, `errM`=1 and `resultM`=0 exactly `TIMEOUT` cycles after the start pulse. A later `completeAAU` is ignored.
- `rst` pulled low during WAIT -> all outputs 0 asynchronously. After release, a MULHSU 1×0xFFFFFFFE completes normally with `signedUnsigned`=1.
